// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_LIMIT = 4'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: values of 5 or more get +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // 5..9 map to 8..12, so the 4-bit sum never wraps
  always_comb begin
    dout = (din >= ADJ_LIMIT) ? din + DIGIT_W'(3) : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, start/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_nxt;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   scratch_nxt;
  logic               acc;
  logic               shift_out;
  logic               load;
  logic               step;
  logic               finish;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Shift the adjusted digits and the binary operand left as one register;
  // the bit leaving the top digit feeds the overflow accumulator
  always_comb begin
    {shift_out, scratch_nxt, shreg_nxt} = {adjusted, shreg, 1'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (count == CNT_W'(1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes and busy derived from the current state
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    bus.busy = 1'b0;
    case (state)
      ST_IDLE:  load = bus.start;
      ST_SHIFT: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        finish   = (count == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, per-cycle shift, and result hand-off on the last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      shreg       <= '0;
      scratch     <= '0;
      acc         <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_out <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (load) begin
        shreg   <= bus.bin_in;
        scratch <= '0;
        acc     <= 1'b0;
        count   <= CNT_W'(WIDTH);
      end else if (step) begin
        shreg   <= shreg_nxt;
        scratch <= scratch_nxt;
        acc     <= acc | shift_out;
        count   <= count - CNT_W'(1);
        if (finish) begin
          bus.bcd_out <= scratch_nxt;
          bus.ovf     <= acc | shift_out;
          bus.done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed handshake cases plus random operands
// against a decimal-arithmetic reference, on a 3-digit and a 2-digit instance.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) a_if ();
  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) b_if ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Low `digits` decimal digits of v, packed four bits per digit
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned digits);
    logic [31:0]  r = '0;
    int unsigned  m = v % pow10(digits);
    for (int unsigned i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int unsigned digits);
    return v >= pow10(digits);
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_if.busy : b_if.busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? a_if.done : b_if.done;
  endfunction

  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? a_if.ovf : b_if.ovf;
  endfunction

  function automatic logic [31:0] get_bcd(input int sel);
    return (sel == 0) ? 32'(a_if.bcd_out) : 32'(b_if.bcd_out);
  endfunction

  task automatic set_start(input int sel, input logic s, input logic [7:0] v);
    if (sel == 0) begin
      a_if.start  = s;
      a_if.bin_in = v;
    end else begin
      b_if.start  = s;
      b_if.bin_in = v;
    end
  endtask

  // Issue one conversion from the current cycle and wait (bounded) for its done pulse
  task automatic conv(input int sel, input logic [7:0] v, input string tag, output int done_cyc);
    int unsigned digits = (sel == 0) ? 3 : 2;
    bit seen = 1'b0;
    int lat = 0;
    int busy_cnt = 0;
    set_start(sel, 1'b1, v);
    @(posedge clk); #1;
    set_start(sel, 1'b0, 8'($urandom));
    if (get_busy(sel)) busy_cnt++;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (get_done(sel)) begin
        seen = 1'b1;
        lat  = n;
      end else if (get_busy(sel)) begin
        busy_cnt++;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd0);
    check({tag, "_bcd"}, get_bcd(sel), ref_bcd(int'(v), digits));
    check({tag, "_ovf"}, 32'(get_ovf(sel)), 32'(ref_ovf(int'(v), digits)));
    done_cyc = cyc;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    int done_cnt, lat;
    logic [31:0] cap;

    set_start(0, 1'b0, 8'd0);
    set_start(1, 1'b0, 8'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_bcd",  32'(a_if.bcd_out), 32'd0);
    check("rst_ovf",  32'(a_if.ovf), 32'd0);
    check("rst_bcd_b", 32'(b_if.bcd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    conv(0, 8'd0, "zero", t0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(a_if.done), 32'd0);

    conv(0, 8'd255, "max", t0);
    @(posedge clk); #1;

    // Each start lands in the previous done cycle
    conv(0, 8'd99, "b2b_99", t0);
    conv(0, 8'd10, "b2b_10", t1);
    conv(0, 8'd1,  "b2b_1",  t2);
    check("b2b_spacing_1", 32'(t1 - t0), 32'd9);
    check("b2b_spacing_2", 32'(t2 - t1), 32'd9);
    @(posedge clk); #1;

    // A second start while busy must be ignored
    set_start(0, 1'b1, 8'd123);
    @(posedge clk); #1;
    set_start(0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    set_start(0, 1'b1, 8'd7);
    @(posedge clk); #1;
    set_start(0, 1'b0, 8'd0);
    done_cnt = 0;
    lat = 0;
    cap = '0;
    for (int n = 3; n <= 25; n++) begin
      if (a_if.done) begin
        done_cnt++;
        lat = n;
        cap = 32'(a_if.bcd_out);
      end
      @(posedge clk); #1;
    end
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_latency", 32'(lat), 32'd8);
    check("ignore_bcd", cap, 32'h123);

    // Reset in the middle of a conversion aborts it
    set_start(0, 1'b1, 8'd200);
    @(posedge clk); #1;
    set_start(0, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(a_if.busy), 32'd0);
    check("abort_done", 32'(a_if.done), 32'd0);
    check("abort_bcd",  32'(a_if.bcd_out), 32'd0);
    check("abort_ovf",  32'(a_if.ovf), 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (a_if.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    conv(0, 8'd42, "after_abort", t0);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      conv(0, 8'($urandom_range(0, 255)), "rand_a", t0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // Two-digit instance: truncation and overflow flag
    conv(1, 8'd255, "d2_255", t0);
    @(posedge clk); #1;
    conv(1, 8'd98, "d2_98", t0);
    @(posedge clk); #1;
    conv(1, 8'd100, "d2_100", t0);
    for (int i = 0; i < 20; i++) begin
      conv(1, 8'($urandom_range(0, 255)), "rand_b", t0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
